// File: rtl/matrix_loader_if.sv
// Element stream, control and matrix result bundle for matrix_loader.
// The loader takes the slave side; whoever feeds and drains it takes master.
interface matrix_loader_if #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 25
);
  logic                       in_valid;
  logic                       in_ready;
  logic [ELEM_W-1:0]          in_data;
  logic                       single;
  logic                       abort;
  logic                       out_valid;
  logic                       out_ready;
  logic [ELEM_W*N_ELEM-1:0]   matrix_a;
  logic [ELEM_W*N_ELEM-1:0]   matrix_b;
  logic [4:0]                 elem_cnt;

  modport master (
    output in_valid, in_data, single, abort, out_ready,
    input  in_ready, out_valid, matrix_a, matrix_b, elem_cnt
  );

  modport slave (
    input  in_valid, in_data, single, abort, out_ready,
    output in_ready, out_valid, matrix_a, matrix_b, elem_cnt
  );
endinterface

// File: rtl/matrix_loader.sv
// Assembles two row-major matrices (A, then B) from an element stream and
// presents them to the operator stage until it acknowledges with out_ready.
module matrix_loader #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 25
) (
  input  logic            clk,
  input  logic            rst_n,
  matrix_loader_if.slave  bus
);

  localparam int MAT_W = ELEM_W * N_ELEM;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [4:0]        cnt, cnt_nxt;
  logic [MAT_W-1:0]  mat_a, mat_b;

  logic xfer;
  logic last;
  logic wr_a;
  logic wr_b;
  logic clr_b;

  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = (state == HOLD);
  assign bus.matrix_a  = mat_a;
  assign bus.matrix_b  = mat_b;
  assign bus.elem_cnt  = cnt;

  assign xfer  = bus.in_valid && bus.in_ready;
  assign last  = (cnt == 5'(N_ELEM - 1));

  // abort wins over any coincident transfer, so it gates every write enable.
  assign wr_a  = xfer && !bus.abort && (state == LOAD_A);
  assign wr_b  = xfer && !bus.abort && (state == LOAD_B);
  assign clr_b = wr_a && last && bus.single;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;

    case (state)
      LOAD_A: begin
        if (xfer) begin
          cnt_nxt = last ? 5'd0 : cnt + 5'd1;
          if (last) state_nxt = bus.single ? HOLD : LOAD_B;
        end
      end
      LOAD_B: begin
        if (xfer) begin
          cnt_nxt = last ? 5'd0 : cnt + 5'd1;
          if (last) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nxt = LOAD_A;
          cnt_nxt   = 5'd0;
        end
      end
      default: begin
        state_nxt = LOAD_A;
        cnt_nxt   = 5'd0;
      end
    endcase

    if (bus.abort) begin
      state_nxt = LOAD_A;
      cnt_nxt   = 5'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: the matrix registers are reset as well, because their zero value is visible on the outputs during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_a <= '0;
      mat_b <= '0;
    end else begin
      if (wr_a) mat_a[ELEM_W*cnt +: ELEM_W] <= bus.in_data;
      if (wr_b) mat_b[ELEM_W*cnt +: ELEM_W] <= bus.in_data;
      if (clr_b) mat_b <= '0;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: streams known matrices through the loader
// and compares handshake, count and matrix outputs against expected values.
module tb_matrix_loader;

  localparam int ELEM_W = 8;
  localparam int N_ELEM = 25;
  localparam int MW     = ELEM_W * N_ELEM;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [MW-1:0] exp_a;
  logic [MW-1:0] exp_b;
  logic [7:0]    d;
  logic          early;
  int            gap;

  matrix_loader_if #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) bus ();

  matrix_loader #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] val);
    bus.in_valid = 1'b1;
    bus.in_data  = val;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.single    = 1'b0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    exp_a = '0;
    exp_b = '0;

    // Reset state
    #3 rst_n = 1'b0;
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_elem_cnt",  bus.elem_cnt,  0);
    check("rst_matrix_a",  bus.matrix_a,  0);
    check("rst_matrix_b",  bus.matrix_b,  0);
    rst_n = 1'b1;

    // Back-to-back A=1..25, B=101..125
    for (int i = 0; i < 2*N_ELEM; i++) begin
      d = (i < N_ELEM) ? 8'(i + 1) : 8'(101 + i - N_ELEM);
      if (i < N_ELEM) exp_a[ELEM_W*i +: ELEM_W] = d;
      else            exp_b[ELEM_W*(i-N_ELEM) +: ELEM_W] = d;
      push(d);
      if (i == N_ELEM - 1) begin
        check("ab_wrap_cnt",       bus.elem_cnt,  0);
        check("ab_mid_out_valid",  bus.out_valid, 0);
        check("ab_mid_in_ready",   bus.in_ready,  1);
      end
      if (i == 2*N_ELEM - 2) check("ab_early_valid", bus.out_valid, 0);
    end
    check("ab_out_valid",  bus.out_valid, 1);
    check("ab_in_ready",   bus.in_ready,  0);
    check("ab_a_first",    bus.matrix_a[7:0],     8'd1);
    check("ab_a_last",     bus.matrix_a[199:192], 8'd25);
    check("ab_b_first",    bus.matrix_b[7:0],     8'd101);
    check("ab_b_last",     bus.matrix_b[199:192], 8'd125);
    check("ab_matrix_a",   bus.matrix_a, exp_a);
    check("ab_matrix_b",   bus.matrix_b, exp_b);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("ab_ack_out_valid", bus.out_valid, 0);
    check("ab_ack_elem_cnt",  bus.elem_cnt,  0);

    // Unary load: A=0x80 everywhere, B forced to zero
    bus.single = 1'b1;
    for (int i = 0; i < N_ELEM; i++) begin
      exp_a[ELEM_W*i +: ELEM_W] = 8'h80;
      push(8'h80);
    end
    bus.single = 1'b0;
    exp_b = '0;
    check("un_out_valid", bus.out_valid, 1);
    check("un_in_ready",  bus.in_ready,  0);
    check("un_matrix_a",  bus.matrix_a,  exp_a);
    check("un_matrix_b",  bus.matrix_b,  exp_b);

    // HOLD ignores input traffic while out_ready stays low
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      step();
      check("hold_out_valid", bus.out_valid, 1);
    end
    check("hold_matrix_a", bus.matrix_a, exp_a);
    check("hold_matrix_b", bus.matrix_b, exp_b);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("hold_ack_out_valid", bus.out_valid, 0);
    check("hold_ack_in_ready",  bus.in_ready,  1);
    check("hold_ack_elem_cnt",  bus.elem_cnt,  0);

    // Abort after 7 A transfers, coincident with a transfer of 0xFF
    for (int i = 0; i < 7; i++) begin
      d = 8'(8'h10 + i);
      exp_a[ELEM_W*i +: ELEM_W] = d;
      push(d);
    end
    check("abort_pre_cnt", bus.elem_cnt, 7);
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    step();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_elem_cnt",  bus.elem_cnt,  0);
    check("abort_in_ready",  bus.in_ready,  1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_slot7",     bus.matrix_a[63:56], 8'h80);
    check("abort_matrix_a",  bus.matrix_a, exp_a);
    exp_a[7:0] = 8'h55;
    push(8'h55);
    check("abort_reload_slot0", bus.matrix_a, exp_a);
    check("abort_reload_cnt",   bus.elem_cnt, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_idle_cnt", bus.elem_cnt, 0);

    // Three loads with random idle gaps and random single on non-final A slots
    for (int l = 0; l < 3; l++) begin
      early = 1'b0;
      for (int i = 0; i < 2*N_ELEM; i++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 8'($urandom);
          bus.single   = 1'($urandom_range(0, 1));
          step();
          if (bus.out_valid) early = 1'b1;
        end
        d = 8'($urandom);
        bus.single = (i == N_ELEM - 1) ? 1'b0 : 1'($urandom_range(0, 1));
        if (i < N_ELEM) exp_a[ELEM_W*i +: ELEM_W] = d;
        else            exp_b[ELEM_W*(i-N_ELEM) +: ELEM_W] = d;
        push(d);
        if (i != 2*N_ELEM - 1 && bus.out_valid) early = 1'b1;
      end
      bus.single = 1'b0;
      check("rnd_no_early_valid", early, 0);
      check("rnd_out_valid", bus.out_valid, 1);
      check("rnd_matrix_a",  bus.matrix_a, exp_a);
      check("rnd_matrix_b",  bus.matrix_b, exp_b);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("rnd_ack_out_valid", bus.out_valid, 0);
    end

    // Asynchronous reset in the middle of the B load
    for (int i = 0; i < N_ELEM + 12; i++) push(8'(i + 1));
    check("mid_b_cnt",      bus.elem_cnt, 12);
    check("mid_b_in_ready", bus.in_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", bus.out_valid, 0);
    check("async_in_ready",  bus.in_ready,  1);
    check("async_elem_cnt",  bus.elem_cnt,  0);
    check("async_matrix_a",  bus.matrix_a,  0);
    check("async_matrix_b",  bus.matrix_b,  0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    step();
    bus.in_valid = 1'b0;
    check("in_rst_no_xfer_cnt", bus.elem_cnt, 0);
    check("in_rst_no_xfer_a",   bus.matrix_a, 0);
    rst_n = 1'b1;

    // Full reload after reset, with out_ready tied high throughout
    exp_a = '0;
    exp_b = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2*N_ELEM; i++) begin
      d = (i < N_ELEM) ? 8'(i * 3) : 8'(255 - i);
      if (i < N_ELEM) exp_a[ELEM_W*i +: ELEM_W] = d;
      else            exp_b[ELEM_W*(i-N_ELEM) +: ELEM_W] = d;
      push(d);
    end
    check("reload_out_valid", bus.out_valid, 1);
    check("reload_matrix_a",  bus.matrix_a,  exp_a);
    check("reload_matrix_b",  bus.matrix_b,  exp_b);
    step();
    check("reload_hold_1cyc", bus.out_valid, 0);
    check("reload_elem_cnt",  bus.elem_cnt,  0);
    bus.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
